// File: rtl/accum_pkg.sv
// Shared definitions for the packet accumulator: FSM state encoding.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Combinational W-bit ripple-carry adder assembled from full-adder cells.
module adder_nbit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Each cell keeps its own carry so the chain is a set of distinct nets.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_fa[W-1].co;

endmodule

// File: rtl/accum_adder_n.sv
// Unsigned packet accumulator with valid/ready handshakes, wrap/saturate
// overflow handling, a sticky overflow flag and a saturating beat counter.
module accum_adder_n #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int CNT_W    = 5,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow,
  output logic [CNT_W-1:0]  out_count
);

  import accum_pkg::*;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] s,
                                               input logic             c);
    if ((SATURATE != 0) && c) return '1;
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_nxt;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               ovf_q, ovf_nxt;
  logic               in_ready_q;
  logic               out_valid_nxt;
  logic               load_out;
  logic               beat;
  logic [ACC_W-1:0]   ext_data;
  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;

  assign in_ready = in_ready_q;
  assign beat     = in_valid & in_ready_q & ~clear;
  assign ext_data = ACC_W'(in_data);

  adder_nbit #(.W(ACC_W)) u_adder (
    .a    (acc_q),
    .b    (ext_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt     = state_q;
    acc_nxt       = acc_q;
    cnt_nxt       = cnt_q;
    ovf_nxt       = ovf_q;
    load_out      = 1'b0;
    out_valid_nxt = out_valid;
    if (clear) begin
      state_nxt     = ST_IDLE;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      ovf_nxt       = 1'b0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            acc_nxt   = ext_data;
            cnt_nxt   = CNT_W'(1);
            ovf_nxt   = 1'b0;
            state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            load_out  = in_last;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc_nxt   = sat_acc(add_sum, add_cout);
            ovf_nxt   = ovf_q | add_cout;
            cnt_nxt   = inc_cnt(cnt_q);
            state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            load_out  = in_last;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_nxt     = ST_IDLE;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            ovf_nxt       = 1'b0;
            out_valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
      if (load_out) out_valid_nxt = 1'b1;
    end
  end

  // in_ready is registered from the next state so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else begin
      state_q    <= state_nxt;
      acc_q      <= acc_nxt;
      cnt_q      <= cnt_nxt;
      ovf_q      <= ovf_nxt;
      in_ready_q <= (state_nxt != ST_HOLD);
      out_valid  <= out_valid_nxt;
      if (load_out) begin
        out_sum      <= acc_nxt;
        out_overflow <= ovf_nxt;
        out_count    <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_accum_adder_n.sv
// Directed bench for accum_adder_n: four parameterisations share one stimulus stream.
module tb_accum_adder_n;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic out_ready;

  logic rdy_a, vld_a, ovf_a;
  logic [19:0] sum_a;
  logic [4:0] cnt_a;
  logic rdy_w, vld_w, ovf_w;
  logic [7:0] sum_w;
  logic [4:0] cnt_w;
  logic rdy_s, vld_s, ovf_s;
  logic [7:0] sum_s;
  logic [4:0] cnt_s;
  logic rdy_c, vld_c, ovf_c;
  logic [19:0] sum_c;
  logic [1:0] cnt_c;

  int total = 0;
  int bad = 0;

  accum_adder_n #(.DATA_W(8), .ACC_W(20), .CNT_W(5), .SATURATE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_overflow(ovf_a), .out_count(cnt_a));

  accum_adder_n #(.DATA_W(8), .ACC_W(8), .CNT_W(5), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
    .out_sum(sum_w), .out_overflow(ovf_w), .out_count(cnt_w));

  accum_adder_n #(.DATA_W(8), .ACC_W(8), .CNT_W(5), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
    .out_sum(sum_s), .out_overflow(ovf_s), .out_count(cnt_s));

  accum_adder_n #(.DATA_W(8), .ACC_W(20), .CNT_W(2), .SATURATE(0)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready),
    .out_sum(sum_c), .out_overflow(ovf_c), .out_count(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  // Present one beat (inputs change at negedge) and return at the negedge after acceptance.
  task automatic beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (rdy_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL beat_ready_timeout: got in_ready=%b want 1", rdy_a);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", vld_a); end
    total++; if (rdy_a !== 1'b0 || rdy_w !== 1'b0 || rdy_s !== 1'b0 || rdy_c !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready: got %b%b%b%b want 0000", rdy_a, rdy_w, rdy_s, rdy_c); end
    total++; if (sum_a !== 20'd0) begin bad++; $display("FAIL rst_out_sum: got %0d want 0", sum_a); end
    total++; if (cnt_a !== 5'd0 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL rst_cnt_ovf: got cnt=%0d ovf=%b want 0 0", cnt_a, ovf_a); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", rdy_a); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    beat(8'd3, 1'b0);
    beat(8'd5, 1'b0);
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", vld_a); end
    beat(8'd250, 1'b1);
    total++; if (vld_a !== 1'b1 || vld_w !== 1'b1 || vld_s !== 1'b1 || vld_c !== 1'b1) begin
      bad++; $display("FAIL basic_valid: got %b%b%b%b want 1111", vld_a, vld_w, vld_s, vld_c); end
    total++; if (sum_a !== 20'd258) begin bad++; $display("FAIL basic_sum: got %0d want 258", sum_a); end
    total++; if (cnt_a !== 5'd3 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL basic_cnt_ovf: got cnt=%0d ovf=%b want 3 0", cnt_a, ovf_a); end
    total++; if (sum_w !== 8'd2 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL basic_wrap8: got sum=%0d ovf=%b want 2 1", sum_w, ovf_w); end
    total++; if (sum_s !== 8'd255 || ovf_s !== 1'b1) begin
      bad++; $display("FAIL basic_sat8: got sum=%0d ovf=%b want 255 1", sum_s, ovf_s); end
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL basic_hold_ready: got %b want 0", rdy_a); end
    @(negedge clk);
    total++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin
      bad++; $display("FAIL basic_drain: got vld=%b rdy=%b want 0 1", vld_a, rdy_a); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(8'hFF, 1'b1);
    total++; if (vld_a !== 1'b1 || sum_a !== 20'd255 || cnt_a !== 5'd1) begin
      bad++; $display("FAIL single_result: got vld=%b sum=%0d cnt=%0d want 1 255 1", vld_a, sum_a, cnt_a); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (vld_a !== 1'b1 || sum_a !== 20'd255 || rdy_a !== 1'b0) begin
        bad++; $display("FAIL bp_stable[%0d]: got vld=%b sum=%0d rdy=%b want 1 255 0", i, vld_a, sum_a, rdy_a); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin
      bad++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", vld_a, rdy_a); end
    beat(8'd2, 1'b1);
    total++; if (vld_a !== 1'b1 || sum_a !== 20'd2 || cnt_a !== 5'd1) begin
      bad++; $display("FAIL bp_next_packet: got vld=%b sum=%0d cnt=%0d want 1 2 1", vld_a, sum_a, cnt_a); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    out_ready = 1'b1;
    beat(8'd200, 1'b0);
    beat(8'd100, 1'b1);
    total++; if (sum_w !== 8'd44 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL ovf_wrap: got sum=%0d ovf=%b want 44 1", sum_w, ovf_w); end
    total++; if (sum_s !== 8'd255 || ovf_s !== 1'b1) begin
      bad++; $display("FAIL ovf_sat: got sum=%0d ovf=%b want 255 1", sum_s, ovf_s); end
    total++; if (sum_a !== 20'd300 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL ovf_wide: got sum=%0d ovf=%b want 300 0", sum_a, ovf_a); end
    @(negedge clk);
    beat(8'd200, 1'b0);
    beat(8'd100, 1'b0);
    beat(8'd1, 1'b1);
    total++; if (sum_s !== 8'd255 || ovf_s !== 1'b1 || cnt_s !== 5'd3) begin
      bad++; $display("FAIL sat_sticky: got sum=%0d ovf=%b cnt=%0d want 255 1 3", sum_s, ovf_s, cnt_s); end
    total++; if (sum_w !== 8'd45 || ovf_w !== 1'b1 || cnt_w !== 5'd3) begin
      bad++; $display("FAIL wrap_three: got sum=%0d ovf=%b cnt=%0d want 45 1 3", sum_w, ovf_w, cnt_w); end
    @(negedge clk);
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    beat(8'd7, 1'b0);
    beat(8'd9, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd4; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    total++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin
      bad++; $display("FAIL clear_idle: got vld=%b rdy=%b want 0 1", vld_a, rdy_a); end
    beat(8'd1, 1'b1);
    total++; if (sum_a !== 20'd1 || cnt_a !== 5'd1 || vld_a !== 1'b1) begin
      bad++; $display("FAIL clear_next: got sum=%0d cnt=%0d vld=%b want 1 1 1", sum_a, cnt_a, vld_a); end
    @(negedge clk);
  endtask

  task automatic test_reset_hold;
    out_ready = 1'b0;
    beat(8'd10, 1'b1);
    total++; if (vld_a !== 1'b1 || sum_a !== 20'd10) begin
      bad++; $display("FAIL rh_pre: got vld=%b sum=%0d want 1 10", vld_a, sum_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (vld_a !== 1'b0 || sum_a !== 20'd0 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL rh_async: got vld=%b sum=%0d rdy=%b want 0 0 0", vld_a, sum_a, rdy_a); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (rdy_a !== 1'b1 || vld_a !== 1'b0) begin
      bad++; $display("FAIL rh_recover: got rdy=%b vld=%b want 1 0", rdy_a, vld_a); end
  endtask

  task automatic test_count_sat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(8'd1, (i == 4));
    total++; if (cnt_c !== 2'd3 || sum_c !== 20'd5 || ovf_c !== 1'b0) begin
      bad++; $display("FAIL cnt2_sat: got cnt=%0d sum=%0d ovf=%b want 3 5 0", cnt_c, sum_c, ovf_c); end
    total++; if (cnt_a !== 5'd5) begin bad++; $display("FAIL cnt5: got %0d want 5", cnt_a); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_clear;
    test_reset_hold;
    test_count_sat;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
